// File: rtl/irq_req_capture_pkg.sv
// Shared constants, vector types and output-FSM state encoding for the
// request-capture stage feeding the 8-to-3 priority encoder.
package irq_req_capture_pkg;

  localparam int IRQ_N = 8;
  localparam int IRQ_W = 3;

  typedef logic [IRQ_N-1:0] irq_vec_t;
  typedef logic [IRQ_W-1:0] irq_id_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } irq_state_t;

endpackage

// File: rtl/irq_prio_pick.sv
// Combinational highest-set-bit picker: index N-1 has the highest priority,
// id is 0 when nothing is set.
module irq_prio_pick
  import irq_req_capture_pkg::*;
#(
  parameter int N = IRQ_N,
  parameter int W = IRQ_W
) (
  input  logic [N-1:0] i_elig,
  output logic         o_any,
  output logic [W-1:0] o_id
);

  assign o_any = |i_elig;

  // Ascending scan so the last (highest) set index overwrites lower ones.
  always_comb begin
    o_id = '0;
    for (int i = 0; i < N; i++) begin
      if (i_elig[i]) o_id = W'(i);
    end
  end

endmodule

// File: rtl/irq_req_capture.sv
// Edge-detecting request capture with per-line mask and a registered
// valid/ack id output. Optional sticky overflow flag under IRQ_CAPTURE_OVF_EN.
module irq_req_capture
  import irq_req_capture_pkg::*;
#(
  parameter int N = IRQ_N,
  parameter int W = IRQ_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  output logic         irq_valid,
  output logic [W-1:0] irq_id,
  input  logic         irq_ack,
  output logic [N-1:0] pending,
  input  logic         ovf_clr,
  output logic         ovf
);

  logic [N-1:0] r_req_q;
  logic [N-1:0] r_pending;
  irq_state_t   r_state;
  logic [W-1:0] r_id;

  logic [N-1:0] w_edge;
  logic         w_hs;
  logic [N-1:0] w_clr_vec;
  logic [N-1:0] w_elig;
  logic         w_any;
  logic [W-1:0] w_pick_id;
  irq_state_t   w_state_nxt;
  logic [W-1:0] w_id_nxt;

  assign w_edge    = req & ~r_req_q;
  assign w_hs      = (r_state == ST_PRESENT) & irq_ack;
  assign w_clr_vec = w_hs ? (N'(1) << r_id) : '0;
  // Edges landing this cycle are deliberately excluded: they reach elig one
  // cycle later through the pending register.
  assign w_elig    = r_pending & ~mask & ~w_clr_vec;

  irq_prio_pick #(
    .N (N),
    .W (W)
  ) u_pick (
    .i_elig (w_elig),
    .o_any  (w_any),
    .o_id   (w_pick_id)
  );

  // Stage p0: raw request history and pending capture (set beats clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_q   <= '0;
      r_pending <= '0;
    end else begin
      r_req_q   <= req;
      r_pending <= (r_pending & ~w_clr_vec) | w_edge;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    case (r_state)
      ST_IDLE: begin
        w_id_nxt = w_pick_id;
        if (w_any) w_state_nxt = ST_PRESENT;
      end
      ST_PRESENT: begin
        // Frozen until acknowledged; no withdrawal on mask or higher arrival.
        if (w_hs) begin
          w_id_nxt    = w_pick_id;
          w_state_nxt = w_any ? ST_PRESENT : ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_id_nxt    = '0;
      end
    endcase
  end

  // Stage p1: registered presentation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_id    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_id    <= w_id_nxt;
    end
  end

  assign irq_valid = (r_state == ST_PRESENT);
  assign irq_id    = r_id;
  assign pending   = r_pending;

`ifdef IRQ_CAPTURE_OVF_EN
  logic r_ovf;
  logic w_ovf_set;

  // A fresh edge on a line still pending (and not being acked now) is lost.
  assign w_ovf_set = |(w_edge & r_pending & ~w_clr_vec);

  always_ff @(posedge clk) begin
    if (rst)            r_ovf <= 1'b0;
    else if (w_ovf_set) r_ovf <= 1'b1;
    else if (ovf_clr)   r_ovf <= 1'b0;
  end

  assign ovf = r_ovf;
`else
  logic w_unused_ovf_clr;
  assign w_unused_ovf_clr = ovf_clr;
  assign ovf              = 1'b0;
`endif

endmodule

// File: tb/tb_irq_req_capture.sv
// Directed and randomized bench for irq_req_capture with a per-line
// behavioural model of the capture/presentation rules.
module tb_irq_req_capture;
  import irq_req_capture_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  irq_vec_t req;
  irq_vec_t mask;
  logic     irq_valid;
  irq_id_t  irq_id;
  logic     irq_ack;
  irq_vec_t pending;
  logic     ovf_clr;
  logic     ovf;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_reqq;
  logic [7:0] m_pend;
  logic       m_valid;
  int         m_id;
  logic       m_ovf;

  irq_req_capture dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mask      (mask),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .irq_ack   (irq_ack),
    .pending   (pending),
    .ovf_clr   (ovf_clr),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model with the inputs seen at this edge, then the DUT.
  task automatic tick();
    logic [7:0] np;
    logic hs, e, c, ovs;
    int best;
    if (rst) begin
      m_reqq = '0; m_pend = '0; m_valid = 1'b0; m_id = 0; m_ovf = 1'b0;
    end else begin
      hs = m_valid && irq_ack;
      ovs = 1'b0;
      best = -1;
      np = '0;
      for (int i = 0; i < 8; i++) begin
        e = req[i] && !m_reqq[i];
        c = hs && (m_id == i);
        np[i] = e || (m_pend[i] && !c);
        if (e && m_pend[i] && !c) ovs = 1'b1;
        if (m_pend[i] && !mask[i] && !c) best = i;
      end
      if (!m_valid || hs) begin
        m_valid = (best >= 0);
        m_id    = (best >= 0) ? best : 0;
      end
`ifdef IRQ_CAPTURE_OVF_EN
      if (ovs) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
`endif
      m_pend = np;
      m_reqq = req;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_ovf;
`ifdef IRQ_CAPTURE_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    rst = 1'b1; req = 8'h20; mask = '0; irq_ack = 1'b0; ovf_clr = 1'b0;
    m_reqq = '0; m_pend = '0; m_valid = 1'b0; m_id = 0; m_ovf = 1'b0;

    // Reset then single request on line 5
    tick(); tick();
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_valid", 32'(irq_valid), 32'h0);
    chk("rst_id", 32'(irq_id), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    rst = 1'b0;
    tick();
    chk("single_pend", 32'(pending), 32'h20);
    chk("single_valid0", 32'(irq_valid), 32'h0);
    tick();
    chk("single_valid", 32'(irq_valid), 32'h1);
    chk("single_id", 32'(irq_id), 32'd5);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("single_ack_valid", 32'(irq_valid), 32'h0);
    chk("single_ack_pend", 32'(pending), 32'h0);
    tick(); tick();
    chk("no_retrig_pend", 32'(pending), 32'h0);
    chk("no_retrig_valid", 32'(irq_valid), 32'h0);

    // Priority and back-to-back on lines 7, 4, 1
    req = 8'h00; tick();
    req = 8'h92; tick();
    chk("b2b_pend", 32'(pending), 32'h92);
    req = 8'h00; irq_ack = 1'b1;
    tick();
    chk("b2b_v7", 32'(irq_valid), 32'h1);
    chk("b2b_id7", 32'(irq_id), 32'd7);
    tick();
    chk("b2b_id4", 32'(irq_id), 32'd4);
    tick();
    chk("b2b_id1", 32'(irq_id), 32'd1);
    chk("b2b_v1", 32'(irq_valid), 32'h1);
    tick();
    chk("b2b_end_valid", 32'(irq_valid), 32'h0);
    chk("b2b_end_pend", 32'(pending), 32'h0);
    irq_ack = 1'b0;

    // Hold rule: id 2 stays despite higher arrival and masking
    req = 8'h04; tick(); tick();
    chk("hold_id2", 32'(irq_id), 32'd2);
    req = 8'h44; mask = 8'h04; tick();
    chk("hold_frozen_a", 32'(irq_id), 32'd2);
    tick();
    chk("hold_frozen_b", 32'(irq_id), 32'd2);
    chk("hold_valid", 32'(irq_valid), 32'h1);
    irq_ack = 1'b1; tick();
    chk("hold_next_valid", 32'(irq_valid), 32'h1);
    chk("hold_next_id6", 32'(irq_id), 32'd6);
    tick();
    chk("hold_drain", 32'(irq_valid), 32'h0);
    chk("hold_masked_pend", 32'(pending), 32'h00);
    irq_ack = 1'b0; mask = '0; req = '0; tick();

    // Masked line is latched but not presented
    mask = 8'h08; req = 8'h08; tick();
    chk("mask_pend", 32'(pending), 32'h08);
    tick();
    chk("mask_valid", 32'(irq_valid), 32'h0);
    mask = '0; tick();
    chk("unmask_valid", 32'(irq_valid), 32'h1);
    chk("unmask_id", 32'(irq_id), 32'd3);

    // Set and clear of line 3 in the same cycle
    req = 8'h00; tick();
    chk("sc_held", 32'(irq_id), 32'd3);
    req = 8'h08; irq_ack = 1'b1; tick();
    chk("sc_pend", 32'(pending), 32'h08);
    chk("sc_valid_gap", 32'(irq_valid), 32'h0);
    irq_ack = 1'b0; tick();
    chk("sc_repres_valid", 32'(irq_valid), 32'h1);
    chk("sc_repres_id", 32'(irq_id), 32'd3);
    irq_ack = 1'b1; tick();
    chk("sc_clear", 32'(pending), 32'h0);
    irq_ack = 1'b0; req = '0; tick();

    // Overflow, clear, and reset mid-presentation
    req = 8'h01; tick();
    chk("ovf_pre", 32'(ovf), 32'h0);
    req = 8'h00; tick();
    chk("ovf_v0", 32'(irq_valid), 32'h1);
    req = 8'h01; tick();
    chk("ovf_set", 32'(ovf), 32'(exp_ovf));
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'h0);
    chk("ovf_still_valid", 32'(irq_valid), 32'h1);
    rst = 1'b1; tick();
    chk("midrst_valid", 32'(irq_valid), 32'h0);
    chk("midrst_id", 32'(irq_id), 32'h0);
    chk("midrst_pend", 32'(pending), 32'h0);
    chk("midrst_ovf", 32'(ovf), 32'h0);
    rst = 1'b0; req = '0; tick();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      req = req ^ 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 7) == 0) mask = 8'($urandom & $urandom);
      irq_ack = ($urandom_range(0, 2) == 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      rst     = ($urandom_range(0, 149) == 0);
      tick();
      chk("rnd_valid", 32'(irq_valid), 32'(m_valid));
      chk("rnd_id", 32'(irq_id), 32'(m_id));
      chk("rnd_pend", 32'(pending), 32'(m_pend));
      chk("rnd_ovf", 32'(ovf), 32'(m_ovf));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
